// File: rtl/cd4b_sync_pkg.sv
// ============================================================================
//  Module   : cd4b_sync_pkg
//  Purpose  : Shared control-priority codes and load-clamp helper for the
//             cd4b_sync descending counter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cd4b_sync_pkg;

    // Per-edge control selection, in decreasing priority order.
    localparam logic [2:0] SEL_CLR  = 3'd0;
    localparam logic [2:0] SEL_PR   = 3'd1;
    localparam logic [2:0] SEL_LD   = 3'd2;
    localparam logic [2:0] SEL_DEC  = 3'd3;
    localparam logic [2:0] SEL_HOLD = 3'd4;

    // Out-of-range load values saturate to the top of the count range.
    function automatic logic [31:0] clamp_load(input logic [31:0] d,
                                               input logic [31:0] modulus);
        return (d < modulus) ? d : (modulus - 32'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cd4b_sync_tff.sv
// ============================================================================
//  Module   : cd4b_sync_tff
//  Purpose  : T flip-flop cell (tff_sync) with synchronous active-low clear
//             and preset plus a parallel-load override.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cd4b_sync_tff (
    input  logic clk,
    input  logic clr_n,
    input  logic pr_n,
    input  logic ld,
    input  logic d,
    input  logic t,
    output logic q
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_q <= 1'b0;
        end else if (!pr_n) begin
            r_q <= 1'b1;
        end else if (ld) begin
            r_q <= d;
        end else if (t) begin
            r_q <= ~r_q;
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/cd4b_sync.sv
// ============================================================================
//  Module   : cd4b_sync
//  Purpose  : Synchronous modulo-MODULUS down counter with clear, preset,
//             parallel load, borrow-out and sticky underflow flag.
//             CD4B_AUTOSTOP_EN selects one-shot mode (stop at zero).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cd4b_sync
    import cd4b_sync_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             CLR,
    input  logic             PR,
    input  logic             T,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             BO,
    output logic             ZERO,
    output logic             UF
);

    localparam logic [WIDTH-1:0] c_top = WIDTH'(MODULUS - 1);

    logic [2:0]       w_sel;
    logic             w_zero;
    logic             w_dec;
    logic             w_wrap;
    logic             w_load;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_low_zero;
    logic [WIDTH-1:0] w_pr_n;
    logic             r_uf;

    always_comb begin
        w_sel      = SEL_HOLD;
        w_zero     = (Q == '0);
        w_dec      = 1'b0;
        w_wrap     = 1'b0;
        w_load     = 1'b0;
        w_load_val = c_top;

        if (!CLR) begin
            w_sel = SEL_CLR;
        end else if (!PR) begin
            w_sel = SEL_PR;
        end else if (LD) begin
            w_sel = SEL_LD;
        end else if (T) begin
            w_sel = SEL_DEC;
        end

        // Zero is never decremented through the toggle chain: it either
        // reloads the top value or holds, depending on the build.
        w_dec = (w_sel == SEL_DEC) && !w_zero;
`ifdef CD4B_AUTOSTOP_EN
        w_wrap = 1'b0;
`else
        w_wrap = (w_sel == SEL_DEC) && w_zero;
`endif
        w_load = (w_sel == SEL_PR) || (w_sel == SEL_LD) || w_wrap;
        if (w_sel == SEL_LD) begin
            w_load_val = WIDTH'(clamp_load(32'(D), 32'(MODULUS)));
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i == 0) begin : g_lsb
            assign w_low_zero[i] = 1'b1;
        end else begin : g_upper
            assign w_low_zero[i] = (Q[i-1:0] == '0);
        end

        // Cells whose preset bit is 0 take the preset through the load path.
        assign w_pr_n[i] = c_top[i] ? PR : 1'b1;

        cd4b_sync_tff u_tff (
            .clk   (clk),
            .clr_n (CLR),
            .pr_n  (w_pr_n[i]),
            .ld    (w_load),
            .d     (w_load_val[i]),
            .t     (w_dec & w_low_zero[i]),
            .q     (Q[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!CLR) begin
            r_uf <= 1'b0;
        end else if ((w_sel == SEL_DEC) && w_zero) begin
            r_uf <= 1'b1;
        end
    end

    assign ZERO = w_zero;
    assign UF   = r_uf;
    assign BO   = w_wrap;

endmodule

`default_nettype wire

// File: tb/tb_cd4b_sync.sv
// ============================================================================
//  Module   : tb_cd4b_sync
//  Purpose  : Scoreboard bench for cd4b_sync, MODULUS=16 and MODULUS=10.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cd4b_sync;

    typedef struct packed {
        logic [3:0] q;
        logic       bo;
        logic       zero;
        logic       uf;
    } exp_t;

    logic       clk = 1'b0;
    logic       CLR = 1'b0;
    logic       PR  = 1'b1;
    logic       T   = 1'b0;
    logic       LD  = 1'b0;
    logic [3:0] D   = 4'd0;

    logic [3:0] q16, q10;
    logic       bo16, zero16, uf16, bo10, zero10, uf10;

    exp_t exp_q16[$];
    exp_t exp_q10[$];

    int tests  = 0;
    int failed = 0;
    int mq  [2] = '{0, 0};
    int muf [2] = '{0, 0};
    int mmod[2] = '{16, 10};

    always #10 clk = ~clk;

    cd4b_sync #(.WIDTH(4), .MODULUS(16)) u_m16 (
        .clk(clk), .CLR(CLR), .PR(PR), .T(T), .LD(LD), .D(D),
        .Q(q16), .BO(bo16), .ZERO(zero16), .UF(uf16)
    );

    cd4b_sync #(.WIDTH(4), .MODULUS(10)) u_m10 (
        .clk(clk), .CLR(CLR), .PR(PR), .T(T), .LD(LD), .D(D),
        .Q(q10), .BO(bo10), .ZERO(zero10), .UF(uf10)
    );

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            failed++;
            $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs, predict this cycle's outputs, then advance the model.
    task automatic step(input logic clr, input logic pr, input logic ld,
                        input logic t, input logic [3:0] d);
        exp_t e;
        @(negedge clk);
        CLR = clr; PR = pr; LD = ld; T = t; D = d;
        for (int k = 0; k < 2; k++) begin
            e.q    = 4'(mq[k]);
            e.zero = (mq[k] == 0);
            e.uf   = muf[k][0];
`ifdef CD4B_AUTOSTOP_EN
            e.bo   = 1'b0;
`else
            e.bo   = clr && pr && !ld && t && (mq[k] == 0);
`endif
            if (k == 0) exp_q16.push_back(e);
            else        exp_q10.push_back(e);

            if (!clr) begin
                mq[k] = 0; muf[k] = 0;
            end else if (!pr) begin
                mq[k] = mmod[k] - 1;
            end else if (ld) begin
                mq[k] = (int'(d) < mmod[k]) ? int'(d) : mmod[k] - 1;
            end else if (t) begin
                if (mq[k] > 0) begin
                    mq[k] = mq[k] - 1;
                end else begin
`ifdef CD4B_AUTOSTOP_EN
                    mq[k] = 0;
`else
                    mq[k] = mmod[k] - 1;
`endif
                    muf[k] = 1;
                end
            end
        end
    endtask

    // Monitor: compares whatever the stimulus side has queued for this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #5;
            if (exp_q16.size() > 0) begin
                e = exp_q16.pop_front();
                check("m16_q",    int'(q16),    int'(e.q));
                check("m16_bo",   int'(bo16),   int'(e.bo));
                check("m16_zero", int'(zero16), int'(e.zero));
                check("m16_uf",   int'(uf16),   int'(e.uf));
            end
            if (exp_q10.size() > 0) begin
                e = exp_q10.pop_front();
                check("m10_q",    int'(q10),    int'(e.q));
                check("m10_bo",   int'(bo10),   int'(e.bo));
                check("m10_zero", int'(zero10), int'(e.zero));
                check("m10_uf",   int'(uf10),   int'(e.uf));
            end
        end
    end

    initial begin
        int wait_cycles;
        // Unchecked power-up clear so Q leaves X.
        repeat (2) @(posedge clk);

        // Reset state, CLR dominating T.
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'd0);

        // Free-running count through a wrap.
        repeat (17) step(1'b1, 1'b1, 1'b0, 1'b1, 4'd0);

        // Load with T asserted, then an out-of-range load (clamps on MODULUS=10).
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'd9);
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'd3);
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'd12);
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'd15);

        // CLR and PR together mid-count, then PR alone.
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'd6);
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'd5);
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b1, 4'd0);

        // Full modulo-10 cycle from zero.
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        repeat (12) step(1'b1, 1'b1, 1'b0, 1'b1, 4'd0);

        // Randomised control mix.
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 19) != 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) != 0),
                 4'($urandom_range(0, 15)));
        end

        // Hold inputs quiet while the monitor drains.
        @(negedge clk);
        CLR = 1'b1; PR = 1'b1; LD = 1'b0; T = 1'b0;
        wait_cycles = 0;
        while ((exp_q16.size() > 0 || exp_q10.size() > 0) && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        check("drain_m16", exp_q16.size(), 0);
        check("drain_m10", exp_q10.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
